// File: rtl/spi_ctrl_pkg.sv
// Shared state encoding for the SPI master control sequencer and its debug/trace taps.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package spi_ctrl_pkg;

    // Raw encodings, kept stable so trace/debug logic can decode estado without the enum.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_WAIT_RX = 3'd2;
    localparam logic [2:0] ST_STORE   = 3'd3;
    localparam logic [2:0] ST_NEXT    = 3'd4;
    localparam logic [2:0] ST_CHECK   = 3'd5;
    localparam logic [2:0] ST_FINISH  = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        START   = ST_START,
        WAIT_RX = ST_WAIT_RX,
        STORE   = ST_STORE,
        NEXT    = ST_NEXT,
        CHECK   = ST_CHECK,
        FINISH  = ST_FINISH
    } state_t;

    // True for every state in which the burst owns chip select and the control register.
    // FINISH is excluded: the control register is being written back in that cycle.
    function automatic logic is_burst_state(input state_t s);
        return (s == START) || (s == WAIT_RX) || (s == STORE) ||
               (s == NEXT)  || (s == CHECK);
    endfunction

endpackage

// File: rtl/fsm_control_spi.sv
// Control FSM sequencing a burst of byte transfers on the SPI master core.
// Latency: send in IDLE -> inicio next cycle; i_RX_DV in WAIT_RX -> wr2 next cycle; 4 cycles/byte outside WAIT_RX.
// Backpressure: waits indefinitely in WAIT_RX for i_RX_DV; inputs outside their qualifying state are ignored.
module fsm_control_spi
    import spi_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic send,
    input  logic trans_ready,
    input  logic i_RX_DV,
    output logic inicio,
    output logic cont_trans,
    output logic wr2,
    output logic hold_ctrl,
    output logic send_sign,
    output logic wr2_c
);

    state_t estado;
    state_t estado_nxt;

    // State register; reset aborts any burst immediately without clearing send.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado <= IDLE;
        end else begin
            estado <= estado_nxt;
        end
    end

    // Next-state logic; each input is only looked at in the one state that qualifies it.
    always_comb begin
        estado_nxt = estado;
        case (estado)
            IDLE:    if (send) estado_nxt = START;
            START:   estado_nxt = WAIT_RX;
            WAIT_RX: if (i_RX_DV) estado_nxt = STORE;
            STORE:   estado_nxt = NEXT;
            NEXT:    estado_nxt = CHECK;
            CHECK:   estado_nxt = trans_ready ? FINISH : START;
            FINISH:  estado_nxt = IDLE;
            default: estado_nxt = IDLE;
        endcase
    end

    // Moore output decode; the strobes are one-hot by construction since each maps to a single state.
    always_comb begin
        inicio     = 1'b0;
        cont_trans = 1'b0;
        wr2        = 1'b0;
        send_sign  = 1'b0;
        wr2_c      = 1'b0;
        hold_ctrl  = is_burst_state(estado);
        case (estado)
            START:  inicio     = 1'b1;
            STORE:  wr2        = 1'b1;
            NEXT:   cont_trans = 1'b1;
            FINISH: begin
                // send_sign is the data bit written by wr2_c, so they always travel together.
                wr2_c     = 1'b1;
                send_sign = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fsm_control_spi.sv
// Directed self-checking bench for the SPI control sequencer.
// Latency: n/a.
// Backpressure: n/a.
module tb_fsm_control_spi;

    logic clk;
    logic rst;
    logic send;
    logic trans_ready;
    logic i_RX_DV;
    logic inicio;
    logic cont_trans;
    logic wr2;
    logic hold_ctrl;
    logic send_sign;
    logic wr2_c;

    int n_checks;
    int n_fail;

    // Output vector order: {inicio, cont_trans, wr2, hold_ctrl, send_sign, wr2_c}
    localparam logic [5:0] O_IDLE   = 6'b000000;
    localparam logic [5:0] O_START  = 6'b100100;
    localparam logic [5:0] O_WAIT   = 6'b000100;
    localparam logic [5:0] O_STORE  = 6'b001100;
    localparam logic [5:0] O_NEXT   = 6'b010100;
    localparam logic [5:0] O_CHECK  = 6'b000100;
    localparam logic [5:0] O_FINISH = 6'b000011;

    fsm_control_spi dut (
        .clk         (clk),
        .rst         (rst),
        .send        (send),
        .trans_ready (trans_ready),
        .i_RX_DV     (i_RX_DV),
        .inicio      (inicio),
        .cont_trans  (cont_trans),
        .wr2         (wr2),
        .hold_ctrl   (hold_ctrl),
        .send_sign   (send_sign),
        .wr2_c       (wr2_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [5:0] expv);
        logic [5:0] obs;
        obs = {inicio, cont_trans, wr2, hold_ctrl, send_sign, wr2_c};
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: outputs observed %b expected %b", tag, obs, expv);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        send        = 1'b0;
        trans_ready = 1'b0;
        i_RX_DV     = 1'b0;

        // 1. Reset held for 3 cycles, then idle with send low.
        #1;
        check("reset_async", O_IDLE);
        for (int i = 0; i < 3; i++) begin
            step();
            check("in_reset", O_IDLE);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_no_send", O_IDLE);
        end

        // i_RX_DV pulse in IDLE is ignored.
        i_RX_DV = 1'b1;
        step();
        check("rxdv_in_idle", O_IDLE);
        i_RX_DV = 1'b0;

        // 2. send -> START for one cycle, then WAIT_RX holds.
        send = 1'b1;
        step();
        check("start1", O_START);
        send = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("wait_rx_hold", O_WAIT);
        end

        // 3. RX byte -> STORE -> NEXT -> CHECK.
        i_RX_DV = 1'b1;
        step();
        check("store1", O_STORE);
        i_RX_DV = 1'b0;
        step();
        check("next1", O_NEXT);
        step();
        check("check1", O_CHECK);

        // 4a. trans_ready low in CHECK -> next byte; i_RX_DV during START is ignored.
        step();
        check("start2", O_START);
        i_RX_DV = 1'b1;
        step();
        check("rxdv_in_start", O_WAIT);
        i_RX_DV = 1'b0;

        // 5. trans_ready level during WAIT_RX is ignored.
        trans_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("trdy_in_wait", O_WAIT);
        end

        // 4b. Last byte: trans_ready high in CHECK -> FINISH -> IDLE.
        i_RX_DV = 1'b1;
        step();
        check("store2", O_STORE);
        i_RX_DV = 1'b0;
        step();
        check("next2", O_NEXT);
        step();
        check("check2", O_CHECK);
        step();
        check("finish", O_FINISH);
        step();
        check("idle_after", O_IDLE);
        trans_ready = 1'b0;
        step();
        check("idle_stays", O_IDLE);

        // send left high across a whole burst restarts on return to IDLE.
        send = 1'b1;
        step();
        check("start3", O_START);
        step();
        check("wait3", O_WAIT);
        i_RX_DV = 1'b1;
        step();
        check("store3", O_STORE);
        i_RX_DV = 1'b0;
        trans_ready = 1'b1;
        step();
        check("next3", O_NEXT);
        step();
        check("check3", O_CHECK);
        step();
        check("finish3", O_FINISH);
        step();
        check("idle_resend", O_IDLE);
        step();
        check("restart", O_START);
        send = 1'b0;
        trans_ready = 1'b0;
        step();
        check("wait4", O_WAIT);

        // 6. Asynchronous reset mid-WAIT_RX, between clock edges.
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_mid", O_IDLE);
        step();
        check("rst_held", O_IDLE);
        rst = 1'b1;
        step();
        check("post_rst_idle", O_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
